pwm_ramp_scheduler: RTL and testbench
=====================================

# pwm_ramp_scheduler

Shared duty-cycle ramp engine for a bank of PWM channels. Up to NCH requesters each submit a ramp command (target duty, step size). A round-robin arbiter grants one command at a time to a single ramp engine. The engine moves that channel's duty register toward the target by one step per PWM period boundary. The `duty` outputs drive the per-channel PWM generators; `period_tick` comes from the PWM period counter wrap.

## Interface
- NCH, 4: number of channels/requesters (2..16).
- DW, 8: duty/step width in bits.
- PERIOD, 100: PWM period in clk cycles; maximum legal duty value (must fit in DW bits).

- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high; clock clk.
- period_tick  in  1  one-cycle pulse at each PWM period wrap.
- req_valid  in  NCH  per-channel command valid.
- req_ready  out  NCH  per-channel command accept; at most one bit high.
- req_target  in  NCH*DW  per-channel target duty; channel i at bits [i*DW +: DW].
- req_step  in  NCH*DW  per-channel step size, same packing.
- duty  out  NCH*DW  per-channel current duty, registered.
- done  out  NCH  one-cycle pulse when that channel's ramp completes.
- busy  out  1  high while the engine is in RAMP or DONE.

## Operation
- FSM states: IDLE, RAMP, DONE.
- IDLE:
  - `req_ready` is combinational. It is high only for the first channel with `req_valid` set, searching upward from `rr_ptr` with wrap-around.
  - The handshake completes when valid and ready are both high. The engine then captures the channel index, target and step.
- Target and step are normalised at capture:
  - target > PERIOD is clamped to PERIOD.
  - step == 0 is treated as 1.
- After capture:
  - If target equals the current duty, go to DONE.
  - Otherwise go to RAMP.
- RAMP: on each `period_tick`, update `duty[ch]`:
  - Up (duty < target): duty + step. If the result would be ≥ target, set duty = target.
  - Down (duty > target): duty − step. If the result would be ≤ target, set duty = target.
  - Arithmetic is done in DW+1 bits. There is no overshoot, no wrap and no underflow.
  - When the updated duty equals target, go to DONE.
- DONE:
  - `done[ch]` pulses for one cycle.
  - `rr_ptr` becomes (ch+1) mod NCH.
  - Go to IDLE.
- In IDLE, `period_tick` is ignored.
- Non-granted channels hold their duty unchanged at all times.
- A requester may drop `req_valid` before the handshake; this has no effect.
- Commands are never queued. A requester holds valid until it sees ready.

## Timing
- Reset values:
  - all `duty` = 0, `done` = 0, `busy` = 0, `req_ready` = 0.
  - state IDLE, `rr_ptr` = 0.
- Reset mid-ramp aborts the command, and all duty returns to 0 on the next edge.
- Capture happens at edge N when the handshake completes. From N+1 the state is RAMP (or DONE) and `busy` = 1.
- A tick sampled at edge M updates duty, visible after M. A tick coincident with the capture edge N is not used; the first usable tick is sampled at N+1 or later.
- On the edge where duty reaches target, the state moves to DONE. On the following edge, `done` is visible for one cycle and `busy` falls.
- The earliest next grant comes one cycle after the `done` pulse, because IDLE re-arbitrates.
- A zero-length ramp (target equals current duty): `done` is high during cycle N+2.
- Ramp length is ceil(|target − duty| / step) ticks.

## Structure
- Shared package `pwm_pkg`:
  - PERIOD default and DW default.
  - The state enum (IDLE/RAMP/DONE).
  - A saturating step function.
- Sub-module `rr_arbiter`, parameterised by NCH. Inputs: request vector and pointer. Outputs: one-hot grant and encoded index. It is purely combinational.
- The top level holds the FSM, the capture registers and the duty register array.

## Test plan
- Single ramp up: ch0 valid, target 20, step 5, ticks every 100 cycles → duty0 goes 5, 10, 15, 20 after ticks 1–4; `done[0]` pulses once; `busy` then falls.
- Saturation and clamp: ch1 target 250, step 30 from duty 0 → target clamped to 100; duty sequence 30, 60, 90, 100; never exceeds 100.
- Ramp down with step 0: ch2 at duty 10, target 7, step 0 → 9, 8, 7 (step treated as 1); `done[2]` pulses.
- Round-robin fairness: all four channels valid from reset, each with target equal to current duty → grants in order 0, 1, 2, 3. After ch1 is served and ch0 is re-requested, the next grant is 2, not 0.
- Zero-length and tick coincidence: target equals duty with `period_tick` high on the capture edge → `done` high in cycle N+2; no duty change.
- Reset mid-operation: assert reset during ch3's ramp at duty 40 → next cycle all duty = 0, `busy` = 0, no `done` pulse; a fresh command afterwards is granted to ch3 with `rr_ptr` = 0.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM ramp scheduler: defaults, FSM states, step helper.
package pwm_pkg;

   localparam int unsigned PeriodDefault = 100;
   localparam int unsigned DwDefault     = 8;

   typedef enum logic [1:0] {StIdle, StRamp, StDone} state_e;

   // One saturating step of cur toward tgt. The result never passes tgt, so it
   // cannot overshoot, wrap or underflow.
   function automatic logic [31:0] sat_step(input logic [31:0] cur,
                                            input logic [31:0] tgt,
                                            input logic [31:0] step);
      logic [31:0] res;
      if (cur < tgt) begin
         res = ((tgt - cur) <= step) ? tgt : cur + step;
      end else if (cur > tgt) begin
         res = ((cur - tgt) <= step) ? tgt : cur - step;
      end else begin
         res = cur;
      end
      return res;
   endfunction

endpackage

// File: rtl/pwm_ramp_scheduler_if.sv
// Per-channel ramp command bus: valid/ready handshake with packed target and step.
interface pwm_ramp_scheduler_if
   import pwm_pkg::*;
#(
   parameter int unsigned NCH = 4,
   parameter int unsigned DW  = DwDefault
);

   logic [NCH-1:0]    req_valid;
   logic [NCH-1:0]    req_ready;
   logic [NCH*DW-1:0] req_target;
   logic [NCH*DW-1:0] req_step;

   modport master (output req_valid, output req_target, output req_step, input req_ready);
   modport slave  (input req_valid, input req_target, input req_step, output req_ready);

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr_i, wrapping.
module rr_arbiter #(
   parameter int unsigned NCH  = 4,
   parameter int unsigned IdxW = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic [NCH-1:0]  req_i,
   input  logic [IdxW-1:0] ptr_i,
   output logic [NCH-1:0]  gnt_o,
   output logic [IdxW-1:0] idx_o
);

   // Scan upward from the pointer and take the first asserted request
   always_comb begin
      logic            found;
      logic [IdxW-1:0] c;
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      c     = '0;
      for (int unsigned k = 0; k < NCH; k++) begin
         c = IdxW'((32'(ptr_i) + k) % NCH);
         if (!found && req_i[c]) begin
            found    = 1'b1;
            gnt_o[c] = 1'b1;
            idx_o    = c;
         end
      end
   end

endmodule

// File: rtl/pwm_ramp_scheduler.sv
// Shared duty-cycle ramp engine: arbitrates ramp commands and steps one channel's
// duty toward its target once per PWM period.
module pwm_ramp_scheduler
   import pwm_pkg::*;
#(
   parameter int unsigned NCH    = 4,
   parameter int unsigned DW     = DwDefault,
   parameter int unsigned PERIOD = PeriodDefault
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 period_tick_i,
   pwm_ramp_scheduler_if.slave  req,
   output logic [NCH*DW-1:0]    duty_o,
   output logic [NCH-1:0]       done_o,
   output logic                 busy_o
);

   localparam int unsigned IdxW = (NCH > 1) ? $clog2(NCH) : 1;

   state_e          state_q;
   logic [IdxW-1:0] ch_q;
   logic [IdxW-1:0] rr_ptr_q;
   logic [DW-1:0]   tgt_q;
   logic [DW-1:0]   step_q;
   logic [DW-1:0]   duty_q [NCH];
   logic [NCH-1:0]  done_q;

   logic [NCH-1:0]  gnt;
   logic [IdxW-1:0] gnt_idx;
   logic [DW-1:0]   raw_tgt;
   logic [DW-1:0]   raw_step;
   logic [DW-1:0]   cap_tgt;
   logic [DW-1:0]   cap_step;
   logic [DW-1:0]   next_duty;

   rr_arbiter #(
      .NCH  (NCH),
      .IdxW (IdxW)
   ) u_arb (
      .req_i (req.req_valid),
      .ptr_i (rr_ptr_q),
      .gnt_o (gnt),
      .idx_o (gnt_idx)
   );

   // Ready mirrors the arbiter grant, but only while idle and out of reset
   always_comb begin
      req.req_ready = (state_q == StIdle && !reset) ? gnt : '0;
   end

   // Normalise the granted command and compute the next ramp value
   always_comb begin
      raw_tgt   = req.req_target[32'(gnt_idx)*DW +: DW];
      raw_step  = req.req_step[32'(gnt_idx)*DW +: DW];
      cap_tgt   = (32'(raw_tgt) > PERIOD) ? DW'(PERIOD) : raw_tgt;
      cap_step  = (raw_step == '0) ? DW'(1) : raw_step;
      next_duty = DW'(sat_step(32'(duty_q[ch_q]), 32'(tgt_q), 32'(step_q)));
   end

   // Engine FSM with capture registers, duty array and done pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         ch_q     <= '0;
         rr_ptr_q <= '0;
         tgt_q    <= '0;
         step_q   <= '0;
         done_q   <= '0;
         for (int i = 0; i < NCH; i++) begin
            duty_q[i] <= '0;
         end
      end else begin
         done_q <= '0;
         unique case (state_q)
            StIdle: begin
               if (|gnt) begin
                  ch_q    <= gnt_idx;
                  tgt_q   <= cap_tgt;
                  step_q  <= cap_step;
                  state_q <= (cap_tgt == duty_q[gnt_idx]) ? StDone : StRamp;
               end
            end
            StRamp: begin
               // A tick on the capture edge was sampled in StIdle and is ignored
               if (period_tick_i) begin
                  duty_q[ch_q] <= next_duty;
                  if (next_duty == tgt_q) begin
                     state_q <= StDone;
                  end
               end
            end
            StDone: begin
               done_q[ch_q] <= 1'b1;
               rr_ptr_q     <= (32'(ch_q) == NCH - 1) ? '0 : ch_q + 1'b1;
               state_q      <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Pack duty registers and drive status outputs
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         duty_o[i*DW +: DW] = duty_q[i];
      end
      done_o = done_q;
      busy_o = (state_q != StIdle);
   end

endmodule

// File: tb/tb_pwm_ramp_scheduler.sv
// Scoreboard bench for pwm_ramp_scheduler: the stimulus side predicts each
// command's duty trajectory and done pulse; a monitor pops and compares them.
module tb_pwm_ramp_scheduler;

   localparam int NCH    = 4;
   localparam int DW     = 8;
   localparam int PERIOD = 100;

   typedef struct {
      bit is_done;
      int ch;
      int val;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              period_tick = 1'b0;
   logic [NCH*DW-1:0] duty_o;
   logic [NCH-1:0]    done_o;
   logic              busy_o;

   pwm_ramp_scheduler_if #(.NCH(NCH), .DW(DW)) bus ();

   pwm_ramp_scheduler #(
      .NCH    (NCH),
      .DW     (DW),
      .PERIOD (PERIOD)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .period_tick_i (period_tick),
      .req           (bus),
      .duty_o        (duty_o),
      .done_o        (done_o),
      .busy_o        (busy_o)
   );

   initial forever #5 clk = ~clk;

   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];

   // Reference state
   int mdl_duty [NCH];
   int mdl_ptr;
   bit pend_valid [NCH];
   int pend_tgt [NCH];
   int pend_step [NCH];
   int tick_per = 10;
   int tick_cnt = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name, input int act);
      checks++;
      errors++;
      $display("FAIL %s: got %0d, expected nothing (t=%0t)", name, act, $time);
   endtask

   // Expected trajectory of one command from the ramp rules, plus its done pulse
   function automatic void model_cmd(input int c, input int tgt, input int st);
      int t;
      int s;
      int d;
      t = (tgt > PERIOD) ? PERIOD : tgt;
      s = (st == 0) ? 1 : st;
      d = mdl_duty[c];
      while (d != t) begin
         if (t > d) d = (d + s >= t) ? t : d + s;
         else       d = (d - s <= t) ? t : d - s;
         sb.push_back('{is_done: 1'b0, ch: c, val: d});
      end
      sb.push_back('{is_done: 1'b1, ch: c, val: 0});
      mdl_duty[c] = t;
   endfunction

   function automatic int mdl_arb();
      for (int k = 0; k < NCH; k++) begin
         if (pend_valid[(mdl_ptr + k) % NCH]) return (mdl_ptr + k) % NCH;
      end
      return -1;
   endfunction

   function automatic void clear_model();
      sb.delete();
      mdl_ptr = 0;
      for (int c = 0; c < NCH; c++) begin
         mdl_duty[c]   = 0;
         pend_valid[c] = 1'b0;
      end
   endfunction

   task automatic drive();
      for (int c = 0; c < NCH; c++) begin
         bus.req_valid[c]             = pend_valid[c];
         bus.req_target[c*DW +: DW]   = DW'(pend_tgt[c]);
         bus.req_step[c*DW +: DW]     = DW'(pend_step[c]);
      end
   endtask

   // Called after inputs settle: if a handshake will complete on the coming edge,
   // check the grant against the reference arbiter and predict the response.
   task automatic handshake(input bit reissue0);
      int g;
      int n;
      int e;
      g = -1;
      n = 0;
      for (int c = 0; c < NCH; c++) begin
         if (bus.req_ready[c]) begin
            n++;
            if (pend_valid[c]) g = c;
         end
      end
      if (n != 0) begin
         chk("ready_onehot", n, 1);
         e = mdl_arb();
         chk("grant_channel", g, e);
         if (g >= 0) begin
            model_cmd(g, pend_tgt[g], pend_step[g]);
            mdl_ptr       = (g + 1) % NCH;
            pend_valid[g] = 1'b0;
            if (reissue0 && g == 1) begin
               pend_valid[0] = 1'b1;
               pend_tgt[0]   = mdl_duty[0];
               pend_step[0]  = 1;
            end
         end
      end
   endtask

   function automatic bit any_pending();
      for (int c = 0; c < NCH; c++) if (pend_valid[c]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic cycle_with_ticks();
      @(negedge clk);
      drive();
      period_tick = (tick_cnt == 0);
      tick_cnt    = (tick_cnt + 1) % tick_per;
      #1;
   endtask

   // Run until every pending command is served and the scoreboard drains
   task automatic run(input int budget, input bit reissue0);
      int cyc;
      cyc = 0;
      while ((any_pending() || busy_o || sb.size() != 0) && cyc < budget) begin
         cycle_with_ticks();
         handshake(reissue0);
         cyc++;
      end
      @(negedge clk);
      period_tick = 1'b0;
      chk("run_completes", int'(cyc < budget), 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < NCH; c++) pend_valid[c] = 1'b0;
      drive();
      period_tick = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      clear_model();
      reset = 1'b0;
   endtask

   task automatic set_cmd(input int c, input int tgt, input int st);
      pend_valid[c] = 1'b1;
      pend_tgt[c]   = tgt;
      pend_step[c]  = st;
   endtask

   // Monitor: every duty change and done pulse must match the scoreboard head
   initial begin
      logic [DW-1:0] prev [NCH];
      exp_t          e;
      for (int c = 0; c < NCH; c++) prev[c] = '0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            for (int c = 0; c < NCH; c++) begin
               if (duty_o[c*DW +: DW] != prev[c]) begin
                  if (sb.size() == 0) begin
                     fail_now("unexpected_duty_change", int'(duty_o[c*DW +: DW]));
                  end else begin
                     e = sb.pop_front();
                     chk("duty_event_kind", int'(e.is_done), 0);
                     chk("duty_event_channel", c, e.ch);
                     chk("duty_value", int'(duty_o[c*DW +: DW]), e.val);
                     chk("duty_within_period", int'(duty_o[c*DW +: DW] <= PERIOD), 1);
                  end
               end
            end
            if (done_o != '0) begin
               if (sb.size() == 0) begin
                  fail_now("unexpected_done", int'(done_o));
               end else begin
                  e = sb.pop_front();
                  chk("done_event_kind", int'(e.is_done), 1);
                  chk("done_vector", int'(done_o), 1 << e.ch);
               end
            end
         end
         for (int c = 0; c < NCH; c++) prev[c] = duty_o[c*DW +: DW];
      end
   end

   initial begin
      int cyc;
      for (int c = 0; c < NCH; c++) begin
         pend_tgt[c]  = 0;
         pend_step[c] = 0;
      end
      clear_model();

      // Reset: requests present but nothing may be accepted
      for (int c = 0; c < NCH; c++) set_cmd(c, 50, 5);
      drive();
      repeat (3) @(negedge clk);
      #1;
      chk("reset_ready", int'(bus.req_ready), 0);
      chk("reset_duty", int'(duty_o), 0);
      chk("reset_done", int'(done_o), 0);
      chk("reset_busy", int'(busy_o), 0);
      for (int c = 0; c < NCH; c++) pend_valid[c] = 1'b0;
      drive();
      reset = 1'b0;

      // Single ramp up with a 100-cycle period
      tick_per = 100;
      tick_cnt = 1;
      set_cmd(0, 20, 5);
      run(2000, 1'b0);
      chk("ramp_up_final", int'(duty_o[0 +: DW]), 20);
      chk("ramp_up_busy_low", int'(busy_o), 0);

      // Clamp target above PERIOD
      tick_per = 10;
      set_cmd(1, 250, 30);
      run(2000, 1'b0);
      chk("clamp_final", int'(duty_o[1*DW +: DW]), PERIOD);

      // Ramp down with step 0 treated as 1
      set_cmd(2, 10, 10);
      run(2000, 1'b0);
      set_cmd(2, 7, 0);
      run(2000, 1'b0);
      chk("step0_final", int'(duty_o[2*DW +: DW]), 7);

      // Round-robin fairness from reset, ch0 re-requested after ch1
      do_reset();
      for (int c = 0; c < NCH; c++) set_cmd(c, 0, 1);
      run(500, 1'b1);

      // Zero-length command with a tick on the capture edge
      @(negedge clk);
      set_cmd(2, mdl_duty[2], 3);
      drive();
      period_tick = 1'b1;
      #1;
      chk("zl_ready", int'(bus.req_ready), 1 << 2);
      handshake(1'b0);
      @(negedge clk);
      drive();
      period_tick = 1'b0;
      #1;
      chk("zl_busy_n1", int'(busy_o), 1);
      chk("zl_done_n1", int'(done_o), 0);
      @(negedge clk);
      #1;
      chk("zl_done_n2", int'(done_o), 1 << 2);
      chk("zl_busy_n2", int'(busy_o), 0);
      chk("zl_duty_unchanged", int'(duty_o[2*DW +: DW]), mdl_duty[2]);
      repeat (2) @(negedge clk);

      // Reset in the middle of a ch3 ramp at duty 40
      tick_per = 3;
      tick_cnt = 0;
      set_cmd(3, 80, 10);
      cyc = 0;
      while (duty_o[3*DW +: DW] != 8'd40 && cyc < 500) begin
         cycle_with_ticks();
         handshake(1'b0);
         cyc++;
      end
      chk("midop_reached_40", int'(duty_o[3*DW +: DW]), 40);
      reset = 1'b1;
      for (int c = 0; c < NCH; c++) pend_valid[c] = 1'b0;
      drive();
      period_tick = 1'b0;
      @(negedge clk);
      #1;
      chk("midop_duty_cleared", int'(duty_o), 0);
      chk("midop_busy", int'(busy_o), 0);
      chk("midop_done", int'(done_o), 0);
      clear_model();
      reset = 1'b0;
      @(negedge clk);
      #1;
      chk("midop_no_late_done", int'(done_o), 0);

      // Fresh command to ch3, then ch1 and ch3 together (pointer back to 0)
      set_cmd(3, 30, 7);
      run(2000, 1'b0);
      chk("fresh_ch3_final", int'(duty_o[3*DW +: DW]), 30);
      set_cmd(1, 12, 4);
      set_cmd(3, 2, 9);
      run(3000, 1'b0);

      // Randomised command mixes
      for (int r = 0; r < 20; r++) begin
         tick_per = $urandom_range(1, 4);
         tick_cnt = 0;
         for (int c = 0; c < NCH; c++) begin
            if ($urandom_range(0, 1) == 1) begin
               set_cmd(c, $urandom_range(0, 255),
                       ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40));
            end
         end
         if (!any_pending()) set_cmd($urandom_range(0, NCH - 1), $urandom_range(0, 255), 13);
         run(5000, 1'b0);
      end
      for (int c = 0; c < NCH; c++) begin
         chk("final_duty", int'(duty_o[c*DW +: DW]), mdl_duty[c]);
      end
      chk("scoreboard_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
